// File: rtl/seg7_scan_mux_if.sv
// Decoder-to-scanner bundle: per-segment input buses plus the multiplexed display pins.
// No latency of its own; pure signal grouping.
// No backpressure: LOAD_i is a fire-and-forget strobe, the display pins are free-running.
interface seg7_scan_mux_if;
   logic       EN_i;
   logic       LOAD_i;
   logic [3:0] SEGa_i;
   logic [3:0] SEGb_i;
   logic [3:0] SEGc_i;
   logic [3:0] SEGd_i;
   logic [3:0] SEGe_i;
   logic [3:0] SEGf_i;
   logic [3:0] SEGg_i;
   logic [6:0] SEG_o;
   logic [3:0] DIG_o;
   logic       FRAME_o;

   // Upstream side: drives the decoder buses and control, observes the pins
   modport master (
      output EN_i, LOAD_i, SEGa_i, SEGb_i, SEGc_i, SEGd_i, SEGe_i, SEGf_i, SEGg_i,
      input  SEG_o, DIG_o, FRAME_o
   );

   // Scanner side
   modport slave (
      input  EN_i, LOAD_i, SEGa_i, SEGb_i, SEGc_i, SEGd_i, SEGe_i, SEGf_i, SEGg_i,
      output SEG_o, DIG_o, FRAME_o
   );
endinterface

// File: rtl/seg7_scan_mux.sv
// 4-digit 7-segment scan multiplexer with tear-free frame-synchronous updates and dead time.
// Display pins are registered: 1-cycle latency from counter/active state; loads apply at the frame boundary.
// No backpressure: loads are always accepted, last load in a frame wins. Optional macro SEG7_LZ_BLANK_EN.
module seg7_scan_mux #(
   parameter int CLK_DIV        = 50000,
   parameter int BLANK_CYC      = 500,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int DIG_ACTIVE_LOW = 1
) (
   input  logic CLK_i,
   input  logic RSTn_i,
   seg7_scan_mux_if.slave bus
);

   localparam int               CNT_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
   localparam logic [6:0]       SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic [3:0]       DIG_OFF   = (DIG_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

   // Slot phases
   localparam logic [0:0] ST_BLANK = 1'b0;
   localparam logic [0:0] ST_DRIVE = 1'b1;

   logic [CNT_W-1:0] div_cnt;
   logic [1:0]       dig_idx;
   logic [3:0][6:0]  in_pat;
   logic [3:0][6:0]  pending;
   logic [3:0][6:0]  active;
   logic             pend_vld;
   logic [0:0]       slot_st;
   logic             frame_end;
   logic [3:0]       lz_blank;
   logic [6:0]       seg_nxt;
   logic [3:0]       dig_nxt;

   // Regroup the decoder's per-segment buses into one {g..a} pattern per digit
   always_comb begin
      in_pat = '0;
      for (int i = 0; i < 4; i++) begin
         in_pat[i] = {bus.SEGg_i[i], bus.SEGf_i[i], bus.SEGe_i[i], bus.SEGd_i[i],
                      bus.SEGc_i[i], bus.SEGb_i[i], bus.SEGa_i[i]};
      end
   end

   assign slot_st   = (div_cnt < CNT_BLANK) ? ST_BLANK : ST_DRIVE;
   assign frame_end = (dig_idx == 2'd3) && (div_cnt == CNT_LAST);

   // Slot timer and digit pointer; held at the start of digit 0 while scanning is disabled
   always_ff @(posedge CLK_i or negedge RSTn_i) begin
      if (!RSTn_i) begin
         div_cnt <= '0;
         dig_idx <= 2'd0;
      end else if (!bus.EN_i) begin
         div_cnt <= '0;
         dig_idx <= 2'd0;
      end else if (div_cnt == CNT_LAST) begin
         div_cnt <= '0;
         dig_idx <= dig_idx + 2'd1;
      end else begin
         div_cnt <= div_cnt + CNT_W'(1);
      end
   end

   // Double buffer: loads park in pending and are promoted only at the frame boundary so a
   // frame never mixes old and new digits; a load on the boundary cycle itself goes straight in
   always_ff @(posedge CLK_i or negedge RSTn_i) begin
      if (!RSTn_i) begin
         pending  <= '0;
         active   <= '0;
         pend_vld <= 1'b0;
      end else if (!bus.EN_i) begin
         if (bus.LOAD_i) begin
            active   <= in_pat;
            pend_vld <= 1'b0;
         end
      end else if (frame_end) begin
         if (bus.LOAD_i) begin
            active <= in_pat;
         end else if (pend_vld) begin
            active <= pending;
         end
         pend_vld <= 1'b0;
      end else if (bus.LOAD_i) begin
         pending  <= in_pat;
         pend_vld <= 1'b1;
      end
   end

`ifdef SEG7_LZ_BLANK_EN
   localparam logic [6:0] GLYPH_ZERO = 7'b0111111;

   // Leading-zero suppression: a "0" hides when everything above it is "0" or unlit; digit 0 always shows
   always_comb begin
      logic upper_clear;
      lz_blank    = 4'b0000;
      upper_clear = 1'b1;
      for (int i = 3; i >= 1; i--) begin
         lz_blank[i] = upper_clear && (active[i] == GLYPH_ZERO);
         upper_clear = upper_clear && ((active[i] == GLYPH_ZERO) || (active[i] == 7'h00));
      end
   end
`else
   assign lz_blank = 4'b0000;
`endif

   // Next pin values: dark during dead time or when disabled, otherwise the selected digit only
   always_comb begin
      seg_nxt = SEG_OFF;
      dig_nxt = DIG_OFF;
      if (bus.EN_i && (slot_st == ST_DRIVE) && !lz_blank[dig_idx]) begin
         seg_nxt = (SEG_ACTIVE_LOW != 0) ? ~active[dig_idx] : active[dig_idx];
         dig_nxt = (DIG_ACTIVE_LOW != 0) ? ~(4'b0001 << dig_idx) : (4'b0001 << dig_idx);
      end
   end

   // Registered pins; async reset blanks the display immediately so no digit is left half-lit
   always_ff @(posedge CLK_i or negedge RSTn_i) begin
      if (!RSTn_i) begin
         bus.SEG_o   <= SEG_OFF;
         bus.DIG_o   <= DIG_OFF;
         bus.FRAME_o <= 1'b0;
      end else begin
         bus.SEG_o   <= seg_nxt;
         bus.DIG_o   <= dig_nxt;
         bus.FRAME_o <= bus.EN_i && frame_end;
      end
   end

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
- Downstream stage of the binary-to-7-segment decoder.
- Consumes the decoder's per-segment buses (bit i of each bus is digit i) and time-multiplexes them onto one shared 7-segment bus with 4 digit enables.
- Provides tear-free frame-synchronous updates and anti-ghosting dead time.
- Drives the board's 4-digit display pins directly.

Parameters:
- CLK_DIV, 50000, clock cycles per digit slot (must be > BLANK_CYC).
- BLANK_CYC, 500, cycles at the start of each slot with all digits off (dead time).
- SEG_ACTIVE_LOW, 1, 1 = segment pins driven low to light.
- DIG_ACTIVE_LOW, 1, 1 = digit enable pins driven low to select.

Ports:
- CLK_i  in  1  system clock
- RSTn_i  in  1  asynchronous active-low reset
- EN_i  in  1  scan enable
- LOAD_i  in  1  capture SEGa_i..SEGg_i this cycle
- SEGa_i .. SEGg_i  in  4 each  segment-on bits from decoder, bit i = digit i, active-high
- SEG_o  out  7  shared segment bus {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
- DIG_o  out  4  digit enables, bit i = digit i, polarity per DIG_ACTIVE_LOW
- FRAME_o  out  1  one-cycle pulse on the last cycle of the digit-3 slot

Behaviour:
- Reset is asynchronous and active-low; one clock; all state is flopped on CLK_i rising edge.
- Reset values:
  - SEG_o = all-inactive (7'h7F when SEG_ACTIVE_LOW).
  - DIG_o = all-inactive (4'hF when DIG_ACTIVE_LOW).
  - FRAME_o = 0.
  - div_cnt = 0, dig_idx = 0.
  - pending and active registers = all segments off; pend_vld = 0.
- Counters:
  - div_cnt runs 0..CLK_DIV-1 and wraps.
  - On wrap, dig_idx advances 0→1→2→3→0.
- Slot FSM (per div_cnt):
  - BLANK: div_cnt < BLANK_CYC; DIG_o and SEG_o are inactive.
  - DRIVE: otherwise; DIG_o selects dig_idx only; SEG_o = active[dig_idx].
- Outputs are registered: SEG_o, DIG_o and FRAME_o reflect counter state of the previous cycle (1-cycle latency).
- FRAME_o = 1 for the cycle registered from dig_idx=3, div_cnt=CLK_DIV-1.
- Frame boundary is the cycle with dig_idx=3 and div_cnt=CLK_DIV-1.
- Data path (tear-free update):
  - LOAD_i=1: the 28 input bits are written to pending; pend_vld <= 1.
  - At the frame boundary: if LOAD_i=1, inputs go straight to active; else if pend_vld, active <= pending. pend_vld <= 0 in both cases.
  - Multiple LOADs within one frame: last one wins.
- EN_i=0:
  - div_cnt and dig_idx are forced to 0; outputs go inactive on the next cycle; FRAME_o = 0.
  - LOAD_i writes directly to active and clears pend_vld.
  - On EN_i rising, scanning restarts at digit 0, BLANK phase, div_cnt=0.
- Reset asserted mid-slot: all outputs go inactive immediately (asynchronously), no partial digit stays lit, and pending data is discarded.
- Width rules: div_cnt width = $clog2(CLK_DIV); dig_idx is 2 bits.

Optional Feature:
- Macro: SEG7_LZ_BLANK_EN (leading-zero blanking).
- With macro:
  - A digit whose active pattern equals glyph "0" ({g..a} = 7'b0111111) is blanked (DIG_o inactive for its slot) if every higher digit is also glyph "0" or blank.
  - Digit 0 is never blanked.
  - Evaluation uses the active register and is registered with the same 1-cycle latency.
- Without macro: every digit is shown as loaded.

Test Plan (CLK_DIV=8, BLANK_CYC=2, both polarities active-low):
1. Hold RSTn_i=0 for 3 cycles → SEG_o=7'h7F, DIG_o=4'hF, FRAME_o=0 throughout.
2. Reset release, EN_i=1, LOAD "1234" (digit3..0 glyphs 0x06,0x5B,0x4F,0x66) while EN_i=0 first → each slot shows 2 cycles of DIG_o=4'hF, then 6 cycles of DIG_o=4'hE with SEG_o=7'h19 (digit0 "4"), then 4'hD/7'h30, 4'hB/7'h24, 4'h7/7'h79. FRAME_o pulses once every 32 cycles.
3. LOAD "8888" (0x7F all digits) mid digit-1 slot → digits 1..3 of the current frame still show old values; from the slot after FRAME_o, SEG_o=7'h00 on every digit.
4. LOAD asserted exactly on the frame-boundary cycle → new data appears in the very next digit-0 DRIVE phase; a LOAD issued 3 cycles earlier in the same frame is overwritten.
5. Deassert EN_i during digit-2 DRIVE → next cycle DIG_o=4'hF, SEG_o=7'h7F; reassert → 2 blank cycles, then digit 0 drives. Pulse RSTn_i low mid-slot → outputs inactive in the same cycle, and the display stays dark until a new LOAD.
6. LOAD "0007" (0x3F,0x3F,0x3F,0x07): with SEG7_LZ_BLANK_EN, digits 3..1 show DIG_o=4'hF and digit 0 shows SEG_o=7'h78. Without the macro, digits 3..1 show SEG_o=7'h40. With the macro, "0000" leaves only digit 0 lit.
